multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS core. It replaces single-cycle decode with a registered FSM that steps each instruction through IF/ID/EX/MEM/WB. It shares one memory/IO port between fetch and data access through a ready handshake, and drives per-state datapath enables. It sits between the instruction register/memory bus and the existing ALU, register file and PC logic.

Parameters:
MEM_TIMEOUT, 0, cycles to wait for mem_ready before trapping with bus_error; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy MEM_TIMEOUT < 2**TO_W.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  level; 1 = execute instructions, 0 = park in IDLE at the next instruction boundary
opcode  in  6  IR[31:26], registered instruction
funct  in  6  IR[5:0]
mem_ready  in  1  memory/IO has completed the current access this cycle
state  out  3  current FSM state
pc_write  out  1  unconditional PC load
pc_write_eq  out  1  load PC if ALU zero
pc_write_ne  out  1  load PC if ALU not zero
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
ir_write  out  1  latch fetched word into IR
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  read request
mem_write  out  1  write request
reg_write  out  1  register-file write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct/opcode-decoded
sftmd  out  1  shift instruction in EX
instr_retired  out  1  one-cycle pulse on the final cycle of each instruction
illegal_instr  out  1  sticky; unsupported opcode
bus_error  out  1  sticky; mem_ready timeout

Behaviour:
- State encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, TRAP=6. The state register is the only register besides the timeout counter and the two sticky flags.
- All outputs other than state, illegal_instr and bus_error are combinational from the registered state, opcode, funct and mem_ready. In IDLE and TRAP every control output is 0.
- Reset, including mid-instruction: on the next edge state=IDLE, counter=0, and illegal_instr, bus_error and all enables are 0. No write of any kind is issued in the cycle after reset.
- IDLE: go to IF when run=1.
- IF: assert mem_read with iord=0, and hold it until mem_ready. In the mem_ready cycle, pulse ir_write and pc_write (alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00), then go to ID. Without mem_ready, stay in IF.
- ID: drive alu_src_a=0, alu_src_b=11, alu_op=00 so ALUOut gets the branch target. Go to EX if the opcode is supported, otherwise set illegal_instr and go to TRAP.
- Supported opcodes: 000000 (R-type), 001xxx (I_format), 100011 (lw), 101011 (sw), 000100 (beq), 000101 (bne), 000010 (j), 000011 (jal).
- EX actions and next state:
  - R-type, non-jr: a=1, b=00, op=10, sftmd for funct in {00,02,03,04,06,07}; next WB.
  - jr (funct 001000): pc_write, pc_src=11; done.
  - I_format: a=1, b=10, op=10; next WB.
  - lw/sw: a=1, b=10, op=00; next MEM.
  - beq: a=1, b=00, op=01, pc_write_eq, pc_src=01; done. bne is the same with pc_write_ne instead.
  - j: pc_write, pc_src=10; done.
  - jal: pc_write, pc_src=10, plus reg_write with reg_dst=10, wb_sel=10; done.
- MEM: iord=1.
  - lw holds mem_read until mem_ready, then goes to WB.
  - sw holds mem_write until mem_ready; done.
- WB: reg_write asserted.
  - R-type: reg_dst=01, wb_sel=00.
  - I_format: reg_dst=00, wb_sel=00.
  - lw: reg_dst=00, wb_sel=01.
  - Done.
- "Done" means: pulse instr_retired, then go to IF if run=1, else IDLE. A run deassertion mid-instruction never aborts the instruction.
- Timeout, when MEM_TIMEOUT>0: the counter clears on entering IF or MEM and increments each cycle mem_ready=0. If it reaches MEM_TIMEOUT while still waiting, set bus_error and go to TRAP.
- A mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success, not a timeout.
- mem_ready outside IF or MEM is ignored.
- TRAP is absorbing until reset.
- Cycle counts: R/I 4, lw 5, sw 4, beq/bne/j/jal/jr 3, each plus the memory wait cycles.

Decomposition:
- Shared package/include holds the state encodings, opcode and funct constants, and the pc_src, reg_dst, wb_sel, alu_src_b and alu_op codes.
- One sub-module, mc_decode, is combinational. It classifies opcode/funct into is_r, is_jr, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_shift and supported. The FSM consumes only these class bits.

Test Plan:
- add (opcode 0, funct 100000), mem_ready held 1, run=1: states 1,2,3,5. WB cycle shows reg_write=1, reg_dst=01, wb_sel=00, then instr_retired=1 and the next state is IF.
- lw with mem_ready delayed 3 cycles in both IF and MEM: 11 cycles total. mem_read is held in each wait; WB shows wb_sel=01, reg_dst=00.
- beq, bne, jal, jr back-to-back: each takes 3 cycles in EX with the correct pc_write_eq/pc_write_ne/pc_src. jal shows reg_dst=10, wb_sel=10.
- Opcode 111111: ID sets illegal_instr=1, state goes to 6 and stays with all enables 0. Reset returns state to 0 and clears the flag.
- MEM_TIMEOUT=4, mem_ready stuck at 0 in IF: bus_error=1 and TRAP after 4 wait cycles. A variant with mem_ready=1 on the 4th cycle gives no error and proceeds to ID.
- run drops during sw MEM wait: the store completes with mem_write until mem_ready, instr_retired pulses, then IDLE. Reset asserted in EX of a jal gives IDLE with no reg_write or pc_write on the following cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: FSM states, opcode/funct
// constants, datapath select codes and the decoded instruction-class bundle.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_TRAP = 3'd6
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [2:0]      OP_IFMT  = 3'b001;
  localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_jr;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_jal;
    logic is_shift;
    logic supported;
  } dec_t;

  // sll, srl, sra, sllv, srlv, srav
  function automatic logic is_shift_funct(input logic [OP_W-1:0] fn);
    return (fn[5:3] == 3'b000) && (fn[2:0] != 3'b001) && (fn[2:0] != 3'b101);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier; the FSM sees only these class bits.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  input  logic [OP_W-1:0] funct_i,
  output dec_t            dec_o
);

  logic r_op;
  logic jr;

  always_comb begin
    r_op  = (opcode_i == OP_RTYPE);
    jr    = r_op && (funct_i == FN_JR);
    dec_o = '0;
    dec_o.is_r     = r_op && !jr;
    dec_o.is_jr    = jr;
    dec_o.is_i     = (opcode_i[5:3] == OP_IFMT);
    dec_o.is_lw    = (opcode_i == OP_LW);
    dec_o.is_sw    = (opcode_i == OP_SW);
    dec_o.is_beq   = (opcode_i == OP_BEQ);
    dec_o.is_bne   = (opcode_i == OP_BNE);
    dec_o.is_j     = (opcode_i == OP_J);
    dec_o.is_jal   = (opcode_i == OP_JAL);
    dec_o.is_shift = r_op && !jr && is_shift_funct(funct_i);
    dec_o.supported = r_op || (opcode_i[5:3] == OP_IFMT) || (opcode_i == OP_LW) ||
                      (opcode_i == OP_SW) || (opcode_i == OP_BEQ) || (opcode_i == OP_BNE) ||
                      (opcode_i == OP_J) || (opcode_i == OP_JAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer sharing one memory port via mem_ready,
// with an optional access timeout and sticky illegal/bus-error traps.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TO_W        = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            mem_ready,
  output logic [2:0]      state,
  output logic            pc_write,
  output logic            pc_write_eq,
  output logic            pc_write_ne,
  output logic [1:0]      pc_src,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      wb_sel,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            sftmd,
  output logic            instr_retired,
  output logic            illegal_instr,
  output logic            bus_error
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            berr_q, berr_d;
  logic            done;
  logic            wait_mem;
  dec_t            dec;

  mc_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec)
  );

  assign state         = state_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = berr_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    illegal_d     = illegal_q;
    berr_d        = berr_q;
    done          = 1'b0;
    wait_mem      = 1'b0;
    pc_write      = 1'b0;
    pc_write_eq   = 1'b0;
    pc_write_ne   = 1'b0;
    pc_src        = PCSRC_ALU;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = RDST_RT;
    wb_sel        = WB_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_op        = ALUOP_ADD;
    sftmd         = 1'b0;
    instr_retired = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_IF;
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = ALUB_FOUR;
          state_d   = S_ID;
        end else begin
          wait_mem = 1'b1;
        end
      end
      S_ID: begin
        alu_src_b = ALUB_IMM_SH;
        if (dec.supported) begin
          state_d = S_EX;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EX: begin
        if (dec.is_jr) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_RS;
          done     = 1'b1;
        end else if (dec.is_r || dec.is_i) begin
          alu_src_a = 1'b1;
          alu_src_b = dec.is_r ? ALUB_RT : ALUB_IMM;
          alu_op    = ALUOP_FUNCT;
          sftmd     = dec.is_shift;
          state_d   = S_WB;
        end else if (dec.is_lw || dec.is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          state_d   = S_MEM;
        end else if (dec.is_beq || dec.is_bne) begin
          alu_src_a   = 1'b1;
          alu_op      = ALUOP_SUB;
          pc_write_eq = dec.is_beq;
          pc_write_ne = dec.is_bne;
          pc_src      = PCSRC_ALUOUT;
          done        = 1'b1;
        end else if (dec.is_j || dec.is_jal) begin
          pc_write  = 1'b1;
          pc_src    = PCSRC_JUMP;
          reg_write = dec.is_jal;
          reg_dst   = dec.is_jal ? RDST_RA : RDST_RT;
          wb_sel    = dec.is_jal ? WB_PC : WB_ALUOUT;
          done      = 1'b1;
        end else begin
          // IR changed under us after ID; treat as illegal rather than guess
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = dec.is_lw;
        mem_write = !dec.is_lw;
        if (mem_ready) begin
          if (dec.is_lw) state_d = S_WB;
          else           done    = 1'b1;
        end else begin
          wait_mem = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = dec.is_r ? RDST_RD : RDST_RT;
        wb_sel    = dec.is_lw ? WB_MDR : WB_ALUOUT;
        done      = 1'b1;
      end
      S_TRAP: ;
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      instr_retired = 1'b1;
      state_d       = run ? S_IF : S_IDLE;
    end

    // ready on the final allowed cycle wins over the timeout
    if ((MEM_TIMEOUT != 0) && wait_mem) begin
      if (cnt_q == TO_LAST) begin
        berr_d  = 1'b1;
        state_d = S_TRAP;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      berr_q    <= berr_d;
    end
  end

endmodule
